// File: rtl/csr_event_sequencer.sv
// Serialises interrupt triggers, governor axlevel updates, software CSR writes and traps
// so that the CSR unit sees at most one state update per cycle.
module csr_event_sequencer #(
  parameter int AX_LEVEL_WIDTH = 3,
  parameter int INT_CODE_WIDTH = 4,
  parameter int ARM_TIMEOUT    = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mstatusMIE,
  input  logic                      mieMTIE,
  input  logic                      mieMEIE,
  input  logic                      reqTimerInterrupt,
  input  logic                      reqExternalInterrupt,
  input  logic                      safePoint,
  input  logic                      triggerExcpt,
  input  logic                      csrWE,
  input  logic                      csrWriteIsAxLevel,
  input  logic                      flushDone,
  input  logic                      axReqValid,
  input  logic [AX_LEVEL_WIDTH-1:0] axReqData,
  output logic                      axReqReady,
  output logic                      triggerInterrupt,
  output logic [INT_CODE_WIDTH-1:0] interruptCode,
  output logic                      axLevelEn,
  output logic [AX_LEVEL_WIDTH-1:0] axLevelData,
  output logic [7:0]                axDropCount,
  output logic                      armTimeout
);

  localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]          CNT_MAX  = CNT_W'(ARM_TIMEOUT);
  localparam logic [INT_CODE_WIDTH-1:0] CODE_MEI = INT_CODE_WIDTH'(11);
  localparam logic [INT_CODE_WIDTH-1:0] CODE_MTI = INT_CODE_WIDTH'(7);

  typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          arm_cnt_reg, arm_cnt_next;
  logic                      arm_timeout_reg, arm_timeout_next;
  logic                      ax_pend_valid_reg, ax_pend_valid_next;
  logic [AX_LEVEL_WIDTH-1:0] ax_pend_data_reg, ax_pend_data_next;
  logic [7:0]                ax_drop_cnt_reg, ax_drop_cnt_next;

  logic ext_req, tmr_req, pending, fire_ok;
  logic sw_ax_write, blocked, ax_en, ax_drop, ax_ready, ax_accept;
  logic [INT_CODE_WIDTH-1:0] sel_code;

  assign ext_req  = mieMEIE & reqExternalInterrupt;
  assign tmr_req  = mieMTIE & reqTimerInterrupt;
  assign pending  = mstatusMIE & (ext_req | tmr_req);
  assign sel_code = ext_req ? CODE_MEI : CODE_MTI;
  // A trap or CSR write owns this cycle's update slot, so the interrupt waits.
  assign fire_ok  = (state_reg == ARMED) & pending & safePoint & ~triggerExcpt & ~csrWE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      arm_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      arm_cnt_reg <= arm_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    arm_cnt_next = '0;
    case (state_reg)
      IDLE:  if (pending) state_next = ARMED;
      ARMED: begin
        if (!pending) begin
          state_next = IDLE;
        end else if (fire_ok) begin
          state_next = FLUSH;
        end else begin
          arm_cnt_next = (arm_cnt_reg == CNT_MAX) ? arm_cnt_reg : arm_cnt_reg + 1'b1;
        end
      end
      FLUSH: if (flushDone) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    triggerInterrupt = fire_ok;
    interruptCode    = fire_ok ? sel_code : '0;
  end

  assign arm_timeout_next = arm_timeout_reg | ((state_reg == ARMED) & (arm_cnt_reg == CNT_MAX));

  assign sw_ax_write = csrWE & csrWriteIsAxLevel;
  assign blocked     = sw_ax_write | triggerExcpt | fire_ok;
  assign ax_en       = ax_pend_valid_reg & ~blocked;
  assign ax_drop     = ax_pend_valid_reg & sw_ax_write;
  assign ax_ready    = ~ax_pend_valid_reg | ax_en;
  assign ax_accept   = axReqValid & ax_ready;

  // A fresh accept overrides drain/drop so a new entry is never lost.
  always_comb begin
    ax_pend_valid_next = ax_pend_valid_reg;
    ax_pend_data_next  = ax_pend_data_reg;
    if (ax_en | ax_drop) ax_pend_valid_next = 1'b0;
    if (ax_accept) begin
      ax_pend_valid_next = 1'b1;
      ax_pend_data_next  = axReqData;
    end
  end

  assign ax_drop_cnt_next = (ax_drop && ax_drop_cnt_reg != 8'hFF) ? ax_drop_cnt_reg + 8'd1
                                                                  : ax_drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_timeout_reg   <= 1'b0;
      ax_pend_valid_reg <= 1'b0;
      ax_pend_data_reg  <= '0;
      ax_drop_cnt_reg   <= '0;
    end else begin
      arm_timeout_reg   <= arm_timeout_next;
      ax_pend_valid_reg <= ax_pend_valid_next;
      ax_pend_data_reg  <= ax_pend_data_next;
      ax_drop_cnt_reg   <= ax_drop_cnt_next;
    end
  end

  assign axReqReady  = ax_ready;
  assign axLevelEn   = ax_en;
  assign axLevelData = ax_pend_data_reg;
  assign axDropCount = ax_drop_cnt_reg;
  assign armTimeout  = arm_timeout_reg;

endmodule

// File: tb/tb_csr_event_sequencer.sv
// Scoreboard bench: stimulus queues expected interrupt codes and axlevel writes,
// a negedge monitor pops and compares whenever the DUT asserts an output.
module tb_csr_event_sequencer;
  localparam int AXW = 3;
  localparam int ICW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic mstatusMIE, mieMTIE, mieMEIE, reqTimerInterrupt, reqExternalInterrupt;
  logic safePoint, triggerExcpt, csrWE, csrWriteIsAxLevel, flushDone;
  logic axReqValid;
  logic [AXW-1:0] axReqData;
  logic axReqReady, triggerInterrupt, axLevelEn, armTimeout;
  logic [ICW-1:0] interruptCode;
  logic [AXW-1:0] axLevelData;
  logic [7:0] axDropCount;

  int errors = 0;
  int checks = 0;
  logic [ICW-1:0] int_q[$];
  logic [AXW-1:0] ax_q[$];

  always #5 clk = ~clk;

  csr_event_sequencer #(.AX_LEVEL_WIDTH(AXW), .INT_CODE_WIDTH(ICW), .ARM_TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .mstatusMIE(mstatusMIE), .mieMTIE(mieMTIE), .mieMEIE(mieMEIE),
    .reqTimerInterrupt(reqTimerInterrupt), .reqExternalInterrupt(reqExternalInterrupt),
    .safePoint(safePoint), .triggerExcpt(triggerExcpt), .csrWE(csrWE),
    .csrWriteIsAxLevel(csrWriteIsAxLevel), .flushDone(flushDone),
    .axReqValid(axReqValid), .axReqData(axReqData), .axReqReady(axReqReady),
    .triggerInterrupt(triggerInterrupt), .interruptCode(interruptCode),
    .axLevelEn(axLevelEn), .axLevelData(axLevelData),
    .axDropCount(axDropCount), .armTimeout(armTimeout)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (triggerInterrupt) begin
        checks++;
        if (int_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_trigger: got code %0d expected no trigger", interruptCode);
        end else begin
          logic [ICW-1:0] exp_code;
          exp_code = int_q.pop_front();
          if (interruptCode !== exp_code) begin
            errors++;
            $display("FAIL int_code: got %0d expected %0d", interruptCode, exp_code);
          end else $display("ok   int_code: %0d", interruptCode);
        end
      end
      if (axLevelEn) begin
        checks++;
        if (ax_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ax_write: got data %0d expected no write", axLevelData);
        end else begin
          logic [AXW-1:0] exp_ax;
          exp_ax = ax_q.pop_front();
          if (axLevelData !== exp_ax) begin
            errors++;
            $display("FAIL ax_data: got %0d expected %0d", axLevelData, exp_ax);
          end else $display("ok   ax_data: %0d", axLevelData);
        end
        checks++;
        if (triggerExcpt || triggerInterrupt || (csrWE && csrWriteIsAxLevel)) begin
          errors++;
          $display("FAIL ax_exclusive: got axLevelEn=1 with trap/int/sw-write expected 0");
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {mstatusMIE, mieMTIE, mieMEIE, reqTimerInterrupt, reqExternalInterrupt} = '0;
    {safePoint, triggerExcpt, csrWE, csrWriteIsAxLevel, flushDone, axReqValid} = '0;
    axReqData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_trigger", triggerInterrupt, 0);
    check("rst_code", interruptCode, 0);
    check("rst_ax_en", axLevelEn, 0);
    check("rst_ax_data", axLevelData, 0);
    check("rst_drop_cnt", axDropCount, 0);
    check("rst_timeout", armTimeout, 0);
    check("rst_ready", axReqReady, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // External beats timer; single-cycle trigger, silent FLUSH
    mstatusMIE = 1; mieMEIE = 1; mieMTIE = 1; reqTimerInterrupt = 1; reqExternalInterrupt = 1;
    tick();
    safePoint = 1; int_q.push_back(4'd11);
    tick();
    tick(3);
    reqTimerInterrupt = 0; reqExternalInterrupt = 0; safePoint = 0; flushDone = 1;
    tick(); flushDone = 0; tick();

    // Trap coincident with safePoint blocks, retry fires timer code
    mieMEIE = 0; reqTimerInterrupt = 1;
    tick();
    safePoint = 1; triggerExcpt = 1;
    @(negedge clk); check("trap_blocks_fire", triggerInterrupt, 0);
    tick();
    safePoint = 0; triggerExcpt = 0;
    tick();
    safePoint = 1; int_q.push_back(4'd7);
    tick();
    safePoint = 0; reqTimerInterrupt = 0; flushDone = 1;
    tick(); flushDone = 0; tick();

    // Withdrawn request returns to IDLE without firing
    reqTimerInterrupt = 1;
    tick(2);
    reqTimerInterrupt = 0; safePoint = 1;
    tick(); safePoint = 0; tick();

    // Arm timeout, sticky
    reqTimerInterrupt = 1;
    tick(1000);
    @(negedge clk); check("timeout_early", armTimeout, 0);
    tick(30);
    @(negedge clk); check("timeout_set", armTimeout, 1);
    reqTimerInterrupt = 0;
    tick(5);
    @(negedge clk); check("timeout_sticky", armTimeout, 1);
    tick();

    // Axlevel accept latency and back-to-back stream
    axReqValid = 1; axReqData = 3'd5; ax_q.push_back(3'd5);
    @(negedge clk); check("ax_latency", axLevelEn, 0);
    tick(); axReqValid = 0; tick();
    axReqValid = 1;
    for (int v = 1; v <= 3; v++) begin
      axReqData = AXW'(v); ax_q.push_back(AXW'(v));
      @(negedge clk); check("ax_stream_ready", axReqReady, 1);
      tick();
    end
    axReqValid = 0; tick(2);

    // Non-axlevel CSR write does not block the governor write
    axReqValid = 1; axReqData = 3'd6; ax_q.push_back(3'd6);
    tick(); axReqValid = 0; csrWE = 1; csrWriteIsAxLevel = 0;
    @(negedge clk); check("ax_other_csr_en", axLevelEn, 1);
    tick(); csrWE = 0; tick();

    // Software axlevel write drops the pending entry
    axReqValid = 1; axReqData = 3'd4;
    tick(); axReqValid = 0; csrWE = 1; csrWriteIsAxLevel = 1;
    @(negedge clk); check("drop_no_write", axLevelEn, 0);
    tick(); csrWE = 0; csrWriteIsAxLevel = 0;
    @(negedge clk); check("drop_cnt_1", axDropCount, 1);
    check("drop_ready", axReqReady, 1);
    for (int i = 1; i < 301; i++) begin
      axReqValid = 1; axReqData = 3'd4;
      tick(); axReqValid = 0; csrWE = 1; csrWriteIsAxLevel = 1;
      tick(); csrWE = 0; csrWriteIsAxLevel = 0;
      if (i == 253) begin
        @(negedge clk); check("drop_cnt_254", axDropCount, 254);
      end else if (i == 254) begin
        @(negedge clk); check("drop_cnt_255", axDropCount, 255);
      end
    end
    @(negedge clk); check("drop_cnt_sat", axDropCount, 255);
    tick();

    // Async reset mid-FLUSH with a held axlevel entry
    mieMTIE = 1; reqTimerInterrupt = 1;
    tick();
    safePoint = 1; int_q.push_back(4'd7);
    tick(); safePoint = 0;
    axReqValid = 1; axReqData = 3'd2;
    tick(); axReqValid = 0; triggerExcpt = 1;
    @(negedge clk); check("pend_held", axReqReady, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trigger", triggerInterrupt, 0);
    check("arst_code", interruptCode, 0);
    check("arst_ax_en", axLevelEn, 0);
    check("arst_ax_data", axLevelData, 0);
    check("arst_ready", axReqReady, 1);
    check("arst_drop_cnt", axDropCount, 0);
    check("arst_timeout", armTimeout, 0);
    @(posedge clk); #1 rst_n = 1'b1; triggerExcpt = 0; safePoint = 1;
    @(negedge clk); check("idle_after_reset", triggerInterrupt, 0);
    tick(); int_q.push_back(4'd7);
    tick();
    safePoint = 0; reqTimerInterrupt = 0; flushDone = 1;
    tick(); flushDone = 0; tick(3);

    check("int_q_drained", int_q.size(), 0);
    check("ax_q_drained", ax_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_event_sequencer.md
Name: csr_event_sequencer

Overview:
- Sequences asynchronous CSR-side events into the CSR unit's single-update-per-cycle discipline: interrupt trigger, approximation-level (axlevel) writes from the hardware governor, architectural CSR writes and traps.
- Sits between the timer, the external interrupt controller, the axlevel governor and the commit stage.
- Drives the CSR unit's triggerInterrupt, interruptCode, axLevelEn and axLevelData.
- Guarantees that trap, interrupt and CSR update never coincide, and that a software write to axlevel always wins over a governor write.

Parameters:
- AX_LEVEL_WIDTH, 3, width of the approximation level.
- INT_CODE_WIDTH, 4, width of the interrupt cause code.
- ARM_TIMEOUT, 1023, maximum number of ARMED cycles before armTimeout is flagged.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mstatusMIE  in  1  global interrupt enable (csrWholeOut.mstatus.MIE).
- mieMTIE  in  1  timer interrupt enable.
- mieMEIE  in  1  external interrupt enable.
- reqTimerInterrupt  in  1  level timer request.
- reqExternalInterrupt  in  1  level external request.
- safePoint  in  1  commit reports a precise boundary where an interrupt may be taken this cycle.
- triggerExcpt  in  1  trap/MRET committing this cycle.
- csrWE  in  1  CSR instruction write committing this cycle.
- csrWriteIsAxLevel  in  1  the csrWE target is CSR_NUM_AXLEVEL.
- flushDone  in  1  pipeline recovery after an interrupt is complete.
- axReqValid  in  1  governor level-change request.
- axReqData  in  AX_LEVEL_WIDTH  requested level.
- axReqReady  out  1  request accepted when valid and ready are both high.
- triggerInterrupt  out  1  one-cycle interrupt trigger to the CSR unit.
- interruptCode  out  INT_CODE_WIDTH  cause code; valid with triggerInterrupt.
- axLevelEn  out  1  write axlevel this cycle.
- axLevelData  out  AX_LEVEL_WIDTH  level to write.
- axDropCount  out  8  saturating count of governor requests discarded by a software write.
- armTimeout  out  1  sticky flag: ARMED lasted longer than ARM_TIMEOUT cycles.

Behaviour:
- Reset (rst_n low, async): state=IDLE, armCnt=0, axPendValid=0, axPendData=0, axDropCount=0, armTimeout=0. While in reset all outputs are 0 except axReqReady=1.
- pending = mstatusMIE & ((mieMEIE & reqExternalInterrupt) | (mieMTIE & reqTimerInterrupt)).
- sel = MEI (code 11) if mieMEIE & reqExternalInterrupt, else MTI (code 7). External always beats timer.
- fireOK = state==ARMED & pending & safePoint & !triggerExcpt & !csrWE.
- triggerInterrupt = fireOK (combinational on registered state). interruptCode = sel when fireOK, else 0.

FSM:
- IDLE: pending -> ARMED.
- ARMED:
  - !pending -> IDLE (request withdrawn; no trigger).
  - fireOK -> FLUSH.
  - Otherwise stay; armCnt increments, saturating.
  - armCnt==ARM_TIMEOUT sets armTimeout (sticky until reset).
  - armCnt clears on leaving ARMED.
- FLUSH: stay until flushDone; then -> IDLE. No trigger while in FLUSH, even if pending.
- A trap in the same cycle as safePoint blocks fire; the FSM stays ARMED and retries at the next safePoint.

Axlevel path:
- 1-entry holding register.
- blocked = (csrWE & csrWriteIsAxLevel) | triggerExcpt | triggerInterrupt.
- axLevelEn = axPendValid & !blocked. axLevelData = axPendData.
- If axPendValid & csrWE & csrWriteIsAxLevel: the pending entry is cleared without being written, and axDropCount increments, saturating at 255.
- axReqReady = !axPendValid | axLevelEn. Fill and drain may occur in the same cycle, giving back-to-back throughput of 1 per cycle.
- Accept latency: a request accepted in cycle t is written at the earliest in t+1.
- A request accepted in the same cycle as a dropping software write is retained (the new entry is not dropped).
- Invariant: at most one of {triggerExcpt, csrWE, triggerInterrupt} is high per cycle. axLevelEn is never high with any of them, except csrWE to a non-axlevel CSR.

Test Plan:
- MIE=1, MEIE=1, MTIE=1, both reqs=1, safePoint=1 one cycle after arming -> triggerInterrupt=1 for 1 cycle with interruptCode=11, then no trigger until flushDone pulses.
- MTIE=1 timer req held, safePoint coincident with triggerExcpt=1 -> no trigger that cycle; next safePoint with no trap -> trigger, interruptCode=7.
- Timer req drops while ARMED -> return to IDLE, triggerInterrupt never asserts; safePoint never asserted for 1030 cycles -> armTimeout=1 and stays 1.
- axReqValid with data 5 in cycle t, no CSR activity -> axLevelEn=1 with axLevelData=5 at t+1; continuous requests 1,2,3 -> written on consecutive cycles.
- Pending axlevel 4 while csrWE=1 and csrWriteIsAxLevel=1 -> axLevelEn=0, entry dropped, axDropCount 0->1; 300 such drops -> axDropCount=255.
- rst_n asserted mid-FLUSH with a pending axlevel entry -> immediately state=IDLE, axPendValid=0, all outputs 0, axReqReady=1.
